// File: rtl/reset_sequencer.sv
// Power-on / soft reset generator: holds NUM_CH reset outputs asserted, then
// releases them in ascending order with prescaled hold and stagger delays.
module reset_sequencer #(
    parameter int PRESCALE      = 2560,
    parameter int HOLD_TICKS    = 38400,
    parameter int SW_HOLD_TICKS = 192,
    parameter int STAGE_TICKS   = 96,
    parameter int NUM_CH        = 4,
    parameter int CNT_W         = 32,
    parameter int ACTIVE_HIGH   = 1
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              sw_req,
    input  logic              ext_hold,
    output logic [NUM_CH-1:0] rst_out,
    output logic              seq_busy,
    output logic              seq_done
);

    localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PW-1:0]    PRESC_MAX    = PW'(PRESCALE - 1);
    localparam logic [CNT_W-1:0] HOLD_LAST    = CNT_W'(HOLD_TICKS - 1);
    localparam logic [CNT_W-1:0] SW_HOLD_LAST = CNT_W'(SW_HOLD_TICKS - 1);
    localparam logic [CNT_W-1:0] STAGE_LAST   = CNT_W'(STAGE_TICKS - 1);

    typedef enum logic [1:0] {
        ST_HOLD  = 2'd0,
        ST_STAGE = 2'd1,
        ST_RUN   = 2'd2
    } state_t;

    state_t             state_r;
    logic [PW-1:0]      presc_r;
    logic [CNT_W-1:0]   hold_cnt_r;
    logic [CNT_W-1:0]   hold_last_r;
    logic [CNT_W-1:0]   stage_cnt_r;
    // Bit k set while channel k is still held; releases shift the mask left,
    // which enforces strictly ascending release order.
    logic [NUM_CH-1:0]  asrt_r;
    logic [NUM_CH-1:0]  rst_out_r;
    logic               seq_busy_r;
    logic               seq_done_r;

    logic               tick_s;
    logic               release_s;
    logic [NUM_CH-1:0]  rel_mask_s;
    logic               last_s;

    function automatic logic [NUM_CH-1:0] drive_level(input logic [NUM_CH-1:0] mask);
        if (ACTIVE_HIGH != 0) begin
            return mask;
        end else begin
            return ~mask;
        end
    endfunction

    assign tick_s     = (presc_r == PRESC_MAX);
    assign rel_mask_s = asrt_r << 1;
    assign last_s     = (rel_mask_s == {NUM_CH{1'b0}});

    // Decide whether this edge releases the next channel.
    always_comb begin
        release_s = 1'b0;
        case (state_r)
            ST_HOLD: begin
                if (tick_s && !ext_hold && (hold_cnt_r == hold_last_r)) begin
                    release_s = 1'b1;
                end else begin
                    release_s = 1'b0;
                end
            end
            ST_STAGE: begin
                if (tick_s && (stage_cnt_r == STAGE_LAST)) begin
                    release_s = 1'b1;
                end else begin
                    release_s = 1'b0;
                end
            end
            default: release_s = 1'b0;
        endcase
    end

    // Sequencer FSM with prescaler, hold/stage counters and registered outputs.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_r     <= ST_HOLD;
            presc_r     <= {PW{1'b0}};
            hold_cnt_r  <= {CNT_W{1'b0}};
            hold_last_r <= HOLD_LAST;
            stage_cnt_r <= {CNT_W{1'b0}};
            asrt_r      <= {NUM_CH{1'b1}};
            rst_out_r   <= drive_level({NUM_CH{1'b1}});
            seq_busy_r  <= 1'b1;
            seq_done_r  <= 1'b0;
        end else if (sw_req) begin
            // Soft request wins over any coincident tick or release.
            state_r     <= ST_HOLD;
            presc_r     <= {PW{1'b0}};
            hold_cnt_r  <= {CNT_W{1'b0}};
            hold_last_r <= SW_HOLD_LAST;
            stage_cnt_r <= {CNT_W{1'b0}};
            asrt_r      <= {NUM_CH{1'b1}};
            rst_out_r   <= drive_level({NUM_CH{1'b1}});
            seq_busy_r  <= 1'b1;
            seq_done_r  <= 1'b0;
        end else begin
            presc_r <= tick_s ? {PW{1'b0}} : presc_r + PW'(1);
            if (release_s) begin
                asrt_r      <= rel_mask_s;
                rst_out_r   <= drive_level(rel_mask_s);
                stage_cnt_r <= {CNT_W{1'b0}};
                if (state_r == ST_HOLD) begin
                    hold_cnt_r <= hold_cnt_r + CNT_W'(1);
                end else begin
                    hold_cnt_r <= hold_cnt_r;
                end
                if (last_s) begin
                    state_r    <= ST_RUN;
                    seq_busy_r <= 1'b0;
                    seq_done_r <= 1'b1;
                end else begin
                    state_r    <= ST_STAGE;
                    seq_busy_r <= 1'b1;
                    seq_done_r <= 1'b0;
                end
            end else begin
                case (state_r)
                    ST_HOLD: begin
                        if (tick_s && !ext_hold) begin
                            hold_cnt_r <= hold_cnt_r + CNT_W'(1);
                        end else begin
                            hold_cnt_r <= hold_cnt_r;
                        end
                    end
                    ST_STAGE: begin
                        if (tick_s) begin
                            stage_cnt_r <= stage_cnt_r + CNT_W'(1);
                        end else begin
                            stage_cnt_r <= stage_cnt_r;
                        end
                    end
                    ST_RUN: begin
                        state_r <= ST_RUN;
                    end
                    default: begin
                        // Unreachable encoding: fall back to a full hold.
                        state_r     <= ST_HOLD;
                        hold_cnt_r  <= {CNT_W{1'b0}};
                        hold_last_r <= HOLD_LAST;
                        stage_cnt_r <= {CNT_W{1'b0}};
                        asrt_r      <= {NUM_CH{1'b1}};
                        rst_out_r   <= drive_level({NUM_CH{1'b1}});
                        seq_busy_r  <= 1'b1;
                        seq_done_r  <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign rst_out  = rst_out_r;
    assign seq_busy = seq_busy_r;
    assign seq_done = seq_done_r;

endmodule

// File: tb/tb_reset_sequencer.sv
// Directed bench for reset_sequencer: a 3-channel active-high instance and a
// 1-channel active-low instance, with hand-computed release cycles.
module tb_reset_sequencer;

    logic       clk;
    logic       reset_n;
    logic       sw_req;
    logic       ext_hold;
    logic [2:0] rst_out;
    logic       seq_busy;
    logic       seq_done;
    logic [0:0] rst_out1;
    logic       seq_busy1;
    logic       seq_done1;

    int n_chk;
    int n_fail;
    int cyc;

    reset_sequencer #(
        .PRESCALE(4), .HOLD_TICKS(5), .SW_HOLD_TICKS(2), .STAGE_TICKS(2),
        .NUM_CH(3), .CNT_W(8), .ACTIVE_HIGH(1)
    ) u_dut (
        .clk(clk), .reset_n(reset_n), .sw_req(sw_req), .ext_hold(ext_hold),
        .rst_out(rst_out), .seq_busy(seq_busy), .seq_done(seq_done)
    );

    reset_sequencer #(
        .PRESCALE(4), .HOLD_TICKS(5), .SW_HOLD_TICKS(2), .STAGE_TICKS(2),
        .NUM_CH(1), .CNT_W(8), .ACTIVE_HIGH(0)
    ) u_dut1 (
        .clk(clk), .reset_n(reset_n), .sw_req(1'b0), .ext_hold(1'b0),
        .rst_out(rst_out1), .seq_busy(seq_busy1), .seq_done(seq_done1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk = n_chk + 1;
        if (got !== exp) begin
            n_fail = n_fail + 1;
            $display("FAIL %s at cycle %0d: got %0h expected %0h", tag, cyc, got, exp);
        end
    endtask

    // Advance to 1 ns after posedge number n (counted from the last restart).
    task automatic tick_to(input int n);
        while (cyc < n) begin
            @(posedge clk);
            cyc = cyc + 1;
        end
        #1;
    endtask

    task automatic restart_por(input logic hold_lvl);
        @(negedge clk);
        reset_n  = 1'b0;
        ext_hold = hold_lvl;
        @(negedge clk);
        reset_n = 1'b1;
        cyc     = 0;
    endtask

    task automatic chk_main(input string tag, input logic [2:0] r, input logic b, input logic d);
        chk_eq({tag, "_rst"},  32'(rst_out),  32'(r));
        chk_eq({tag, "_busy"}, 32'(seq_busy), 32'(b));
        chk_eq({tag, "_done"}, 32'(seq_done), 32'(d));
    endtask

    initial begin
        n_chk    = 0;
        n_fail   = 0;
        cyc      = 0;
        reset_n  = 1'b0;
        sw_req   = 1'b0;
        ext_hold = 1'b0;
        #22;
        chk_main("reset", 3'b111, 1'b1, 1'b0);
        chk_eq("reset_rst1",  32'(rst_out1),  32'd0);
        chk_eq("reset_done1", 32'(seq_done1), 32'd0);

        // Power-on sequence: releases at 20 / 28 / 36.
        @(negedge clk);
        reset_n = 1'b1;
        cyc     = 0;
        tick_to(19);
        chk_main("por19", 3'b111, 1'b1, 1'b0);
        chk_eq("por19_rst1", 32'(rst_out1), 32'd0);
        chk_eq("por19_busy1", 32'(seq_busy1), 32'd1);
        tick_to(20);
        chk_main("por20", 3'b110, 1'b1, 1'b0);
        chk_eq("por20_rst1",  32'(rst_out1),  32'd1);
        chk_eq("por20_done1", 32'(seq_done1), 32'd1);
        chk_eq("por20_busy1", 32'(seq_busy1), 32'd0);
        tick_to(27);
        chk_main("por27", 3'b110, 1'b1, 1'b0);
        tick_to(28);
        chk_main("por28", 3'b100, 1'b1, 1'b0);
        tick_to(35);
        chk_main("por35", 3'b100, 1'b1, 1'b0);
        tick_to(36);
        chk_main("por36", 3'b000, 1'b0, 1'b1);

        // Soft reset from RUN on edge 50: releases at 58 / 66 / 74.
        tick_to(49);
        sw_req = 1'b1;
        tick_to(50);
        sw_req = 1'b0;
        chk_main("sw50", 3'b111, 1'b1, 1'b0);
        chk_eq("sw50_rst1", 32'(rst_out1), 32'd1);
        tick_to(57);
        chk_main("sw57", 3'b111, 1'b1, 1'b0);
        tick_to(58);
        chk_main("sw58", 3'b110, 1'b1, 1'b0);
        tick_to(65);
        chk_main("sw65", 3'b110, 1'b1, 1'b0);
        tick_to(66);
        chk_main("sw66", 3'b100, 1'b1, 1'b0);
        tick_to(73);
        chk_main("sw73", 3'b100, 1'b1, 1'b0);
        tick_to(74);
        chk_main("sw74", 3'b000, 1'b0, 1'b1);

        // sw_req on the edge that would release ch1 (28): nothing releases.
        restart_por(1'b0);
        tick_to(27);
        sw_req = 1'b1;
        tick_to(28);
        sw_req = 1'b0;
        chk_main("coin28", 3'b111, 1'b1, 1'b0);
        tick_to(35);
        chk_main("coin35", 3'b111, 1'b1, 1'b0);
        tick_to(36);
        chk_main("coin36", 3'b110, 1'b1, 1'b0);
        tick_to(44);
        chk_main("coin44", 3'b100, 1'b1, 1'b0);
        tick_to(51);
        chk_main("coin51", 3'b100, 1'b1, 1'b0);
        tick_to(52);
        chk_main("coin52", 3'b000, 1'b0, 1'b1);

        // Async reset mid-STAGE, between clock edges, then full timing again.
        restart_por(1'b0);
        tick_to(30);
        chk_main("astg30", 3'b100, 1'b1, 1'b0);
        #2;
        reset_n = 1'b0;
        #1;
        chk_main("async", 3'b111, 1'b1, 1'b0);
        @(negedge clk);
        reset_n = 1'b1;
        cyc     = 0;
        tick_to(19);
        chk_main("rep19", 3'b111, 1'b1, 1'b0);
        tick_to(20);
        chk_main("rep20", 3'b110, 1'b1, 1'b0);
        tick_to(28);
        chk_main("rep28", 3'b100, 1'b1, 1'b0);
        tick_to(36);
        chk_main("rep36", 3'b000, 1'b0, 1'b1);

        // ext_hold high through edge 40: unfrozen ticks 44..60 -> 60 / 68 / 76.
        restart_por(1'b1);
        tick_to(40);
        ext_hold = 1'b0;
        chk_main("eh40", 3'b111, 1'b1, 1'b0);
        tick_to(59);
        chk_main("eh59", 3'b111, 1'b1, 1'b0);
        tick_to(60);
        chk_main("eh60", 3'b110, 1'b1, 1'b0);
        tick_to(67);
        chk_main("eh67", 3'b110, 1'b1, 1'b0);
        tick_to(68);
        chk_main("eh68", 3'b100, 1'b1, 1'b0);
        tick_to(75);
        chk_main("eh75", 3'b100, 1'b1, 1'b0);
        tick_to(76);
        chk_main("eh76", 3'b000, 1'b0, 1'b1);

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end

endmodule
